wb_regfile_unit: RTL and testbench
==================================

Name: wb_regfile_unit

Overview:
Write-back end of the MEM/WB pipeline interface. Consumes the registered MEM/WB outputs, selects the write-back value, and commits it to the 32-entry architectural register file. It also serves the two decode-stage read ports with same-cycle write bypass, drives the write-back forwarding source for the EX-stage hazard unit, and counts retired instructions.

Parameters:
XLEN, 32, data width of registers and write-back path
CNT_W, 64, width of retired-instruction counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
mem_data_in  input  XLEN  load data from MEM/WB register
alu_result_in  input  XLEN  ALU result from MEM/WB register
rd_in  input  5  destination register index from MEM/WB
reg_write_in  input  1  register write enable from MEM/WB
mem_to_reg_in  input  1  1 = write load data, 0 = write ALU result
instr_valid_in  input  1  MEM/WB slot holds a real (non-bubble) instruction
rs1_addr  input  5  decode read port 1 index
rs2_addr  input  5  decode read port 2 index
rs1_data  output  XLEN  read port 1 data (bypassed)
rs2_data  output  XLEN  read port 2 data (bypassed)
wb_data_out  output  XLEN  selected write-back value (forwarding source)
wb_rd_out  output  5  write-back destination (forwarding source)
wb_en_out  output  1  write-back is architecturally effective
retire_count  output  CNT_W  retired-instruction counter

Behaviour:
- Clock/reset: single clock clk. Reset is asynchronous and active-high, port name reset. All state clears immediately on reset assertion, independent of clk.
- Write-back select (combinational): wb_data = mem_to_reg_in ? mem_data_in : alu_result_in.
- Effective write (combinational): wb_en = reg_write_in & instr_valid_in & (rd_in != 0).
  - wb_data_out = wb_data.
  - wb_rd_out = rd_in.
  - wb_en_out = wb_en.
- Register file: 31 storage registers x1..x31, each XLEN bits. x0 has no storage.
  - On the rising clk edge with wb_en=1, reg[rd_in] <= wb_data.
  - Writes targeting x0 are discarded.
  - Writes with instr_valid_in=0 are discarded, even if reg_write_in=1.
- Read ports (combinational, zero latency):
  - Address 0 always returns 0.
  - Else, if wb_en=1 and the address equals rd_in, return wb_data. This is the write-first bypass, so decode sees the value committing this cycle.
  - Else return the stored reg[addr].
  - Both ports may bypass simultaneously when rs1_addr == rs2_addr == rd_in.
- Retire counter: on the rising edge, if instr_valid_in=1, retire_count <= retire_count + 1.
  - Counts independently of reg_write_in, so stores and branches count.
  - Wraps modulo 2^CNT_W with no flag.
- Reset values:
  - All of x1..x31 = 0.
  - retire_count = 0.
  - Combinational outputs follow their inputs. With MEM/WB also in reset (all inputs 0): rs1_data/rs2_data = 0, wb_data_out = 0, wb_rd_out = 0, wb_en_out = 0.
- Reset mid-operation: a write pending on the same edge reset deasserts is lost. Registers stay 0 until the first rising edge with reset low.
- Latency:
  - Write visible in storage 1 cycle after the edge.
  - Visible at read ports in the same cycle via bypass.
  - retire_count updates 1 cycle after the valid slot.
- No X propagation: all outputs are defined for any input combination once reset has been applied.

Test Plan:
- Reset mid-run: write x5 = 0xDEADBEEF, then assert reset asynchronously between edges -> rs1_addr=5 reads 0 immediately, retire_count = 0, and both stay 0 until the next valid write.
- ALU write then read: rd_in=3, alu_result_in=0x0000_1234, mem_to_reg_in=0, reg_write_in=1, valid=1 -> same cycle rs1_addr=3 gives 0x1234 (bypass). Next cycle, with reg_write_in=0, it still gives 0x1234 from storage.
- Load select: mem_to_reg_in=1, mem_data_in=0xCAFEF00D, alu_result_in=0x11111111, rd_in=7 -> wb_data_out=0xCAFEF00D and x7 holds 0xCAFEF00D after the edge.
- x0 protection: rd_in=0, reg_write_in=1, alu_result_in=0xFFFFFFFF -> wb_en_out=0, and rs1_addr=0 / rs2_addr=0 both read 0 in this and all later cycles.
- Bubble suppression: instr_valid_in=0, reg_write_in=1, rd_in=9, data 0xAAAA5555 -> x9 unchanged (reads its prior value 0x0), wb_en_out=0, retire_count unchanged.
- Dual bypass and counter: 10 consecutive valid cycles, the last one writing x12=0x55 with rs1_addr=rs2_addr=12 -> both ports return 0x55 that cycle and retire_count = 10. Preload retire_count near 2^CNT_W-1 (force or short-CNT_W build) -> wraps to 0.

Source files
------------

// File: rtl/wb_regfile_unit.sv
// Write-back stage: selects the MEM/WB result, commits it to x1..x31, serves two
// bypassed decode read ports, exports the forwarding source and counts retirements.
module wb_regfile_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [XLEN-1:0]  mem_data_in,
  input  logic [XLEN-1:0]  alu_result_in,
  input  logic [4:0]       rd_in,
  input  logic             reg_write_in,
  input  logic             mem_to_reg_in,
  input  logic             instr_valid_in,
  input  logic [4:0]       rs1_addr,
  input  logic [4:0]       rs2_addr,
  output logic [XLEN-1:0]  rs1_data,
  output logic [XLEN-1:0]  rs2_data,
  output logic [XLEN-1:0]  wb_data_out,
  output logic [4:0]       wb_rd_out,
  output logic             wb_en_out,
  output logic [CNT_W-1:0] retire_count
);

  logic [XLEN-1:0]  wb_data;
  logic             wb_en;
  logic [XLEN-1:0]  regs_reg [1:31];
  logic [CNT_W-1:0] retire_count_reg;

  assign wb_data = mem_to_reg_in ? mem_data_in : alu_result_in;
  // Bubbles and x0 targets never become architectural writes.
  assign wb_en   = reg_write_in & instr_valid_in & (rd_in != 5'd0);

  assign wb_data_out  = wb_data;
  assign wb_rd_out    = rd_in;
  assign wb_en_out    = wb_en;
  assign retire_count = retire_count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 1; i < 32; i++) begin
        regs_reg[i] <= '0;
      end
    end else if (wb_en) begin
      regs_reg[rd_in] <= wb_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retire_count_reg <= '0;
    end else if (instr_valid_in) begin
      retire_count_reg <= retire_count_reg + CNT_W'(1);
    end
  end

  // Write-first bypass: decode sees the value committing on this edge.
  always_comb begin
    rs1_data = '0;
    if (rs1_addr != 5'd0) begin
      if (wb_en && (rs1_addr == rd_in)) begin
        rs1_data = wb_data;
      end else begin
        rs1_data = regs_reg[rs1_addr];
      end
    end
  end

  always_comb begin
    rs2_data = '0;
    if (rs2_addr != 5'd0) begin
      if (wb_en && (rs2_addr == rd_in)) begin
        rs2_data = wb_data;
      end else begin
        rs2_data = regs_reg[rs2_addr];
      end
    end
  end

endmodule

// File: tb/tb_wb_regfile_unit.sv
// Scoreboard bench for wb_regfile_unit: stimulus queues expected outputs, a
// negedge monitor pops and compares them. A 4-bit-counter instance checks wrap.
module tb_wb_regfile_unit;

  localparam int SEL_RS1 = 0, SEL_RS2 = 1, SEL_WBD = 2, SEL_WBR = 3,
                 SEL_WBE = 4, SEL_CNT = 5, SEL_CNT_S = 6;

  typedef struct {
    string       name;
    int          sel;
    logic [63:0] exp;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] mem_data_in, alu_result_in;
  logic [4:0]  rd_in, rs1_addr, rs2_addr;
  logic        reg_write_in, mem_to_reg_in, instr_valid_in;
  logic [31:0] rs1_data, rs2_data, wb_data_out;
  logic [4:0]  wb_rd_out;
  logic        wb_en_out;
  logic [63:0] retire_count;

  logic [31:0] s_rs1_data, s_rs2_data, s_wb_data_out;
  logic [4:0]  s_wb_rd_out;
  logic        s_wb_en_out;
  logic [3:0]  s_retire_count;

  exp_t q[$];
  int   checks = 0;
  int   passed = 0;
  int   fails  = 0;

  always #5 clk = ~clk;

  wb_regfile_unit #(.XLEN(32), .CNT_W(64)) dut (
    .clk(clk), .reset(reset),
    .mem_data_in(mem_data_in), .alu_result_in(alu_result_in),
    .rd_in(rd_in), .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in),
    .instr_valid_in(instr_valid_in),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .wb_data_out(wb_data_out), .wb_rd_out(wb_rd_out), .wb_en_out(wb_en_out),
    .retire_count(retire_count)
  );

  wb_regfile_unit #(.XLEN(32), .CNT_W(4)) dut_small (
    .clk(clk), .reset(reset),
    .mem_data_in(mem_data_in), .alu_result_in(alu_result_in),
    .rd_in(rd_in), .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in),
    .instr_valid_in(instr_valid_in),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(s_rs1_data), .rs2_data(s_rs2_data),
    .wb_data_out(s_wb_data_out), .wb_rd_out(s_wb_rd_out), .wb_en_out(s_wb_en_out),
    .retire_count(s_retire_count)
  );

  task automatic drive(input logic rst, input logic v, input logic rw, input logic m2r,
                       input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] mem,
                       input logic [4:0] a1, input logic [4:0] a2);
    reset          = rst;
    instr_valid_in = v;
    reg_write_in   = rw;
    mem_to_reg_in  = m2r;
    rd_in          = rd;
    alu_result_in  = alu;
    mem_data_in    = mem;
    rs1_addr       = a1;
    rs2_addr       = a2;
  endtask

  task automatic expect_val(input string name, input int sel, input logic [63:0] v);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = v;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every cycle's outputs are settled at the falling edge.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [63:0] act;
      e = q.pop_front();
      case (e.sel)
        SEL_RS1:   act = {32'd0, rs1_data};
        SEL_RS2:   act = {32'd0, rs2_data};
        SEL_WBD:   act = {32'd0, wb_data_out};
        SEL_WBR:   act = {59'd0, wb_rd_out};
        SEL_WBE:   act = {63'd0, wb_en_out};
        SEL_CNT:   act = retire_count;
        default:   act = {60'd0, s_retire_count};
      endcase
      checks++;
      if (act === e.exp) begin
        passed++;
      end else begin
        fails++;
        $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", e.name, act, e.exp, $time);
      end
    end
  end

  initial begin
    drive(1'b1, 0, 0, 0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0);
    tick();

    // Reset state with all inputs idle
    expect_val("rst_rs1", SEL_RS1, 64'h0);
    expect_val("rst_rs2", SEL_RS2, 64'h0);
    expect_val("rst_wbd", SEL_WBD, 64'h0);
    expect_val("rst_wbr", SEL_WBR, 64'h0);
    expect_val("rst_wbe", SEL_WBE, 64'h0);
    expect_val("rst_cnt", SEL_CNT, 64'h0);
    tick();

    // ALU write to x3, bypassed
    drive(1'b0, 1, 1, 0, 5'd3, 32'h0000_1234, 32'h0, 5'd3, 5'd0);
    expect_val("alu_bypass_rs1", SEL_RS1, 64'h1234);
    expect_val("alu_rs2_x0", SEL_RS2, 64'h0);
    expect_val("alu_wbd", SEL_WBD, 64'h1234);
    expect_val("alu_wbr", SEL_WBR, 64'd3);
    expect_val("alu_wbe", SEL_WBE, 64'd1);
    expect_val("alu_cnt", SEL_CNT, 64'd0);
    tick();

    // Non-writing valid instruction; x3 now read from storage
    drive(1'b0, 1, 0, 0, 5'd3, 32'h0000_9999, 32'h0, 5'd3, 5'd0);
    expect_val("alu_stored_rs1", SEL_RS1, 64'h1234);
    expect_val("nowrite_wbe", SEL_WBE, 64'd0);
    expect_val("cnt_after1", SEL_CNT, 64'd1);
    tick();

    // Load select into x7
    drive(1'b0, 1, 1, 1, 5'd7, 32'h1111_1111, 32'hCAFE_F00D, 5'd7, 5'd3);
    expect_val("load_wbd", SEL_WBD, 64'hCAFE_F00D);
    expect_val("load_bypass_rs1", SEL_RS1, 64'hCAFE_F00D);
    expect_val("load_rs2_x3", SEL_RS2, 64'h1234);
    expect_val("cnt_after2", SEL_CNT, 64'd2);
    tick();

    drive(1'b0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 5'd7, 5'd0);
    expect_val("load_stored_rs1", SEL_RS1, 64'hCAFE_F00D);
    expect_val("cnt_after3", SEL_CNT, 64'd3);
    tick();

    // x0 protection
    drive(1'b0, 1, 1, 0, 5'd0, 32'hFFFF_FFFF, 32'h0, 5'd0, 5'd0);
    expect_val("x0_wbe", SEL_WBE, 64'd0);
    expect_val("x0_wbd", SEL_WBD, 64'hFFFF_FFFF);
    expect_val("x0_rs1", SEL_RS1, 64'h0);
    expect_val("x0_rs2", SEL_RS2, 64'h0);
    expect_val("bubble_not_counted", SEL_CNT, 64'd3);
    tick();

    // Bubble with reg_write set must not write x9 or count
    drive(1'b0, 0, 1, 0, 5'd9, 32'hAAAA_5555, 32'h0, 5'd9, 5'd0);
    expect_val("bubble_wbe", SEL_WBE, 64'd0);
    expect_val("bubble_rs1", SEL_RS1, 64'h0);
    expect_val("cnt_after_x0", SEL_CNT, 64'd4);
    tick();

    drive(1'b0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 5'd9, 5'd0);
    expect_val("bubble_x9_stored", SEL_RS1, 64'h0);
    expect_val("x0_later_rs2", SEL_RS2, 64'h0);
    expect_val("bubble_cnt", SEL_CNT, 64'd4);
    tick();

    // x5 = DEADBEEF then asynchronous reset between edges
    drive(1'b0, 1, 1, 0, 5'd5, 32'hDEAD_BEEF, 32'h0, 5'd5, 5'd0);
    expect_val("x5_bypass", SEL_RS1, 64'hDEAD_BEEF);
    tick();

    drive(1'b0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 5'd5, 5'd0);
    expect_val("x5_stored", SEL_RS1, 64'hDEAD_BEEF);
    expect_val("cnt_before_rst", SEL_CNT, 64'd5);
    tick();

    drive(1'b1, 0, 0, 0, 5'd0, 32'h0, 32'h0, 5'd5, 5'd3);
    expect_val("async_rst_x5", SEL_RS1, 64'h0);
    expect_val("async_rst_x3", SEL_RS2, 64'h0);
    expect_val("async_rst_cnt", SEL_CNT, 64'd0);
    expect_val("async_rst_cnt_s", SEL_CNT_S, 64'd0);
    #1;
    checks++;
    if (rs1_data !== 32'h0) begin
      fails++;
      $display("FAIL direct_async_rst_x5: got 0x%0h expected 0x0 at %0t", rs1_data, $time);
    end else begin
      passed++;
    end
    checks++;
    if (retire_count !== 64'd0) begin
      fails++;
      $display("FAIL direct_async_rst_cnt: got 0x%0h expected 0x0 at %0t", retire_count, $time);
    end else begin
      passed++;
    end
    tick();

    drive(1'b0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 5'd5, 5'd7);
    expect_val("post_rst_x5", SEL_RS1, 64'h0);
    expect_val("post_rst_x7", SEL_RS2, 64'h0);
    expect_val("post_rst_cnt", SEL_CNT, 64'd0);
    tick();

    // Ten consecutive valid cycles; last one writes x12 with dual bypass
    for (int i = 0; i < 10; i++) begin
      if (i < 9) begin
        drive(1'b0, 1, 0, 0, 5'd12, 32'h0, 32'h0, 5'd12, 5'd12);
        expect_val("run_rs1_empty", SEL_RS1, 64'h0);
      end else begin
        drive(1'b0, 1, 1, 0, 5'd12, 32'h55, 32'h0, 5'd12, 5'd12);
        expect_val("dual_bypass_rs1", SEL_RS1, 64'h55);
        expect_val("dual_bypass_rs2", SEL_RS2, 64'h55);
      end
      expect_val("run_cnt", SEL_CNT, 64'(i));
      tick();
    end

    drive(1'b0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 5'd12, 5'd12);
    expect_val("run_cnt_10", SEL_CNT, 64'd10);
    expect_val("run_cnt_s_10", SEL_CNT_S, 64'd10);
    expect_val("x12_stored_rs1", SEL_RS1, 64'h55);
    expect_val("x12_stored_rs2", SEL_RS2, 64'h55);
    tick();

    // Second dual bypass with a direct same-cycle comparison
    drive(1'b0, 0, 1, 1, 5'd12, 32'h0, 32'h0000_0055, 5'd12, 5'd12);
    drive(1'b0, 1, 1, 1, 5'd12, 32'h0, 32'h0000_0055, 5'd12, 5'd12);
    #1;
    checks++;
    if ((rs1_data !== wb_data_out) || (rs2_data !== wb_data_out) || (wb_data_out !== 32'h55)) begin
      fails++;
      $display("FAIL direct_dual_bypass: rs1 0x%0h rs2 0x%0h wbd 0x%0h at %0t",
               rs1_data, rs2_data, wb_data_out, $time);
    end else begin
      passed++;
    end
    tick();

    // Five more valid slots: 4-bit counter passes 15 and wraps to 0
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1, 0, 0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0);
      tick();
    end
    drive(1'b0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0);
    expect_val("wrap_cnt_s", SEL_CNT_S, 64'd0);
    expect_val("wide_cnt_16", SEL_CNT, 64'd16);
    tick();

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 5 && q.size() > 0; i++) begin
      @(negedge clk);
    end
    #1;
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      fails++;
      $display("FAIL %s: never checked, expected 0x%0h", e.name, e.exp);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
